// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the splitter sequencing states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR1,
        S_DATA1,
        S_DATA2,
        S_ERR1,
        S_ERR
    } state_e;

endpackage

// File: rtl/ahb_dword_splitter.sv
// 64-bit AHB-Lite slave to 32-bit AHB-Lite master bridge: passes word-or-smaller
// transfers as one beat and splits doublewords into low/high 32-bit beats.
module ahb_dword_splitter
    import ahb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL_S,
    input  logic [1:0]  HTRANS_S,
    input  logic [31:0] HADDR_S,
    input  logic        HWRITE_S,
    input  logic [2:0]  HSIZE_S,
    input  logic        HREADY_S,
    input  logic [63:0] HWDATA_S,
    output logic [63:0] HRDATA_S,
    output logic        HREADYOUT_S,
    output logic        HRESP_S,
    output logic [1:0]  HTRANS_M,
    output logic [31:0] HADDR_M,
    output logic        HWRITE_M,
    output logic [2:0]  HSIZE_M,
    output logic [31:0] HWDATA_M,
    input  logic [31:0] HRDATA_M,
    input  logic        HREADY_M,
    input  logic        HRESP_M
);

    state_e      state, state_nxt, state_after;
    logic [31:0] addr_q;
    logic        write_q;
    logic [2:0]  size_q;
    logic        dw_q;
    logic [31:0] rdlo_q;
    logic        accept;
    logic        misalign;
    logic        dn_err;
    logic        unused;

    assign unused   = HTRANS_S[0];
    assign dn_err   = HRESP_M & ~HREADY_M;
    assign misalign = (HSIZE_S == HSIZE_DWORD) && (HADDR_S[2:0] != 3'b000);
    assign accept   = HSEL_S & HTRANS_S[1] & HREADY_S & ((state == S_IDLE) | HREADYOUT_S);

    // Where to go when the current upstream data phase finishes this cycle.
    assign state_after = accept ? (misalign ? S_ERR1 : S_ADDR1) : S_IDLE;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            dw_q    <= 1'b0;
            rdlo_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= HADDR_S;
                write_q <= HWRITE_S;
                size_q  <= HSIZE_S;
                dw_q    <= (HSIZE_S == HSIZE_DWORD);
            end
            if ((state == S_DATA1) && dw_q && HREADY_M) begin
                rdlo_q <= HRDATA_M;
            end
        end
    end

    // Upstream response: combinational from the downstream handshake in data states.
    always_comb begin
        HREADYOUT_S = 1'b1;
        HRESP_S     = 1'b0;
        HRDATA_S    = addr_q[2] ? {HRDATA_M, 32'h0} : {32'h0, HRDATA_M};
        case (state)
            S_ADDR1: HREADYOUT_S = 1'b0;
            S_DATA1: begin
                if (dn_err) begin
                    HRESP_S     = 1'b1;
                    HREADYOUT_S = 1'b0;
                end else begin
                    HREADYOUT_S = dw_q ? 1'b0 : HREADY_M;
                end
            end
            S_DATA2: begin
                HRDATA_S = {HRDATA_M, rdlo_q};
                if (dn_err) begin
                    HRESP_S     = 1'b1;
                    HREADYOUT_S = 1'b0;
                end else begin
                    HREADYOUT_S = HREADY_M;
                end
            end
            S_ERR1: begin
                HRESP_S     = 1'b1;
                HREADYOUT_S = 1'b0;
            end
            S_ERR:   HRESP_S = 1'b1;
            default: ;
        endcase
    end

    // Next state and downstream address/data decode.
    always_comb begin
        state_nxt = state;
        HTRANS_M  = HTRANS_IDLE;
        HADDR_M   = '0;
        HWRITE_M  = 1'b0;
        HSIZE_M   = '0;
        HWDATA_M  = '0;
        case (state)
            S_IDLE: state_nxt = state_after;
            S_ADDR1: begin
                HTRANS_M = HTRANS_NONSEQ;
                HADDR_M  = {addr_q[31:3], addr_q[2] & ~dw_q, addr_q[1:0]};
                HWRITE_M = write_q;
                HSIZE_M  = dw_q ? HSIZE_WORD : size_q;
                if (HREADY_M) state_nxt = S_DATA1;
            end
            S_DATA1: begin
                HWDATA_M = (dw_q | ~addr_q[2]) ? HWDATA_S[31:0] : HWDATA_S[63:32];
                if (dn_err) begin
                    state_nxt = S_ERR;
                end else if (dw_q) begin
                    // High beat address phase overlaps the low beat data phase.
                    HTRANS_M = HTRANS_SEQ;
                    HADDR_M  = {addr_q[31:3], 3'b100};
                    HWRITE_M = write_q;
                    HSIZE_M  = HSIZE_WORD;
                    if (HREADY_M) state_nxt = S_DATA2;
                end else if (HREADY_M) begin
                    state_nxt = state_after;
                end
            end
            S_DATA2: begin
                HWDATA_M = HWDATA_S[63:32];
                if (dn_err) begin
                    state_nxt = S_ERR;
                end else if (HREADY_M) begin
                    state_nxt = state_after;
                end
            end
            S_ERR1:  state_nxt = S_ERR;
            S_ERR:   state_nxt = state_after;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahb_dword_splitter.sv
// Directed scoreboard bench for ahb_dword_splitter: expectations queued at issue,
// upstream completions and downstream transfers checked by a negedge monitor.
module tb_ahb_dword_splitter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL_S;
    logic [1:0]  HTRANS_S;
    logic [31:0] HADDR_S;
    logic        HWRITE_S;
    logic [2:0]  HSIZE_S;
    logic        HREADY_S;
    logic [63:0] HWDATA_S;
    logic [63:0] HRDATA_S;
    logic        HREADYOUT_S;
    logic        HRESP_S;
    logic [1:0]  HTRANS_M;
    logic [31:0] HADDR_M;
    logic        HWRITE_M;
    logic [2:0]  HSIZE_M;
    logic [31:0] HWDATA_M;
    logic [31:0] HRDATA_M;
    logic        HREADY_M;
    logic        HRESP_M;

    ahb_dword_splitter dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HSEL_S      (HSEL_S),
        .HTRANS_S    (HTRANS_S),
        .HADDR_S     (HADDR_S),
        .HWRITE_S    (HWRITE_S),
        .HSIZE_S     (HSIZE_S),
        .HREADY_S    (HREADY_S),
        .HWDATA_S    (HWDATA_S),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HTRANS_M    (HTRANS_M),
        .HADDR_M     (HADDR_M),
        .HWRITE_M    (HWRITE_M),
        .HSIZE_M     (HSIZE_M),
        .HWDATA_M    (HWDATA_M),
        .HRDATA_M    (HRDATA_M),
        .HREADY_M    (HREADY_M),
        .HRESP_M     (HRESP_M)
    );

    initial forever #5 HCLK = ~HCLK;

    typedef struct {
        int unsigned cyc;
        logic        chk_data;
        logic [63:0] rdata;
        logic        resp;
    } up_exp_t;

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic        chk_wdata;
        logic [31:0] wdata;
    } dn_exp_t;

    up_exp_t     up_q[$];
    dn_exp_t     dn_q[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;
    int unsigned t0;

    initial forever begin
        @(posedge HCLK);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic up_addr(input logic [31:0] a, input logic w, input logic [2:0] sz);
        HSEL_S   = 1'b1;
        HTRANS_S = 2'b10;
        HADDR_S  = a;
        HWRITE_S = w;
        HSIZE_S  = sz;
    endtask

    task automatic up_idle();
        HSEL_S   = 1'b0;
        HTRANS_S = 2'b00;
        HADDR_S  = '0;
        HWRITE_S = 1'b0;
        HSIZE_S  = '0;
    endtask

    task automatic dn_drive(input logic rdy, input logic [31:0] d, input logic r);
        HREADY_M = rdy;
        HRDATA_M = d;
        HRESP_M  = r;
    endtask

    task automatic push_up(input int unsigned c, input logic chk, input logic [63:0] d, input logic r);
        up_exp_t e;
        e.cyc = c; e.chk_data = chk; e.rdata = d; e.resp = r;
        up_q.push_back(e);
    endtask

    task automatic push_dn(input logic [1:0] tr, input logic [31:0] a, input logic w,
                           input logic [2:0] sz, input logic chk, input logic [31:0] wd);
        dn_exp_t e;
        e.trans = tr; e.addr = a; e.write = w; e.size = sz; e.chk_wdata = chk; e.wdata = wd;
        dn_q.push_back(e);
    endtask

    // Monitor: tracks upstream and downstream data phases from the bus handshakes.
    initial begin
        logic    up_dph;
        logic    dn_dph;
        up_exp_t ue;
        dn_exp_t de;
        dn_exp_t dcur;
        up_dph = 1'b0;
        dn_dph = 1'b0;
        dcur   = '{2'b00, 32'h0, 1'b0, 3'b000, 1'b0, 32'h0};
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                up_dph = 1'b0;
                dn_dph = 1'b0;
            end else begin
                if (up_dph && HREADYOUT_S) begin
                    if (up_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL up_unexpected: completion with resp %b, none expected (cycle %0d)", HRESP_S, cyc);
                    end else begin
                        ue = up_q.pop_front();
                        check("up_cycle", 64'(cyc), 64'(ue.cyc));
                        check("up_resp", 64'(HRESP_S), 64'(ue.resp));
                        if (ue.chk_data) check("up_rdata", HRDATA_S, ue.rdata);
                    end
                    up_dph = 1'b0;
                end
                if (HREADYOUT_S && HSEL_S && HTRANS_S[1] && HREADY_S) up_dph = 1'b1;

                if (dn_dph && HREADY_M) begin
                    if (dcur.chk_wdata) check("dn_wdata", 64'(HWDATA_M), 64'(dcur.wdata));
                    dn_dph = 1'b0;
                end
                if (HTRANS_M[1] && HREADY_M) begin
                    if (dn_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL dn_unexpected: trans %h addr %h, none expected (cycle %0d)", HTRANS_M, HADDR_M, cyc);
                        dcur.chk_wdata = 1'b0;
                    end else begin
                        de = dn_q.pop_front();
                        check("dn_addr_phase", 64'({HTRANS_M, HADDR_M, HWRITE_M, HSIZE_M}),
                              64'({de.trans, de.addr, de.write, de.size}));
                        dcur = de;
                    end
                    dn_dph = 1'b1;
                end
            end
        end
    end

    initial begin
        HRESET   = 1'b1;
        HREADY_S = 1'b1;
        HWDATA_S = '0;
        up_idle();
        dn_drive(1'b1, 32'h0, 1'b0);
        repeat (2) step();
        check("rst_ctrl", 64'({HTRANS_M, HWRITE_M, HSIZE_M, HREADYOUT_S, HRESP_S}), 64'h02);
        check("rst_haddr", 64'(HADDR_M), 64'h0);
        check("rst_hwdata", 64'(HWDATA_M), 64'h0);
        HRESET = 1'b0;
        step();

        // Word read at 0x1004: upper lane, one wait state.
        t0 = cyc;
        up_addr(32'h1004, 1'b0, 3'd2);
        push_dn(2'b10, 32'h1004, 1'b0, 3'd2, 1'b0, 32'h0);
        push_up(t0 + 2, 1'b1, 64'hAABBCCDD_00000000, 1'b0);
        step(); up_idle();
        step(); dn_drive(1'b1, 32'hAABBCCDD, 1'b0);
        step(); dn_drive(1'b1, 32'h0, 1'b0);

        // Dword write at 0x2000.
        t0 = cyc;
        up_addr(32'h2000, 1'b1, 3'd3);
        push_dn(2'b10, 32'h2000, 1'b1, 3'd2, 1'b1, 32'h33334444);
        push_dn(2'b11, 32'h2004, 1'b1, 3'd2, 1'b1, 32'h11112222);
        push_up(t0 + 3, 1'b0, 64'h0, 1'b0);
        step(); up_idle(); HWDATA_S = 64'h11112222_33334444;
        step();
        step();
        step(); HWDATA_S = '0;

        // Dword read at 0x3000 with two downstream waits on the high beat.
        t0 = cyc;
        up_addr(32'h3000, 1'b0, 3'd3);
        push_dn(2'b10, 32'h3000, 1'b0, 3'd2, 1'b0, 32'h0);
        push_dn(2'b11, 32'h3004, 1'b0, 3'd2, 1'b0, 32'h0);
        push_up(t0 + 5, 1'b1, 64'h00000006_00000005, 1'b0);
        step(); up_idle();
        step(); dn_drive(1'b1, 32'h5, 1'b0);
        step(); dn_drive(1'b0, 32'h0, 1'b0);
        step(); dn_drive(1'b0, 32'h0, 1'b0);
        step(); dn_drive(1'b1, 32'h6, 1'b0);
        step(); dn_drive(1'b1, 32'h0, 1'b0);

        // Downstream error on the low beat of a dword read.
        t0 = cyc;
        up_addr(32'h5000, 1'b0, 3'd3);
        push_dn(2'b10, 32'h5000, 1'b0, 3'd2, 1'b0, 32'h0);
        push_up(t0 + 3, 1'b0, 64'h0, 1'b1);
        step(); up_idle();
        step(); dn_drive(1'b0, 32'h0, 1'b1);
        #1;
        check("err1_resp_rdy", 64'({HRESP_S, HREADYOUT_S}), 64'h2);
        check("err1_htrans", 64'(HTRANS_M), 64'h0);
        step(); dn_drive(1'b1, 32'h0, 1'b1);
        #1;
        check("err2_htrans", 64'(HTRANS_M), 64'h0);
        step(); dn_drive(1'b1, 32'h0, 1'b0);

        // Misaligned dword: no downstream transfer, two-cycle upstream error.
        t0 = cyc;
        up_addr(32'h4004, 1'b0, 3'd3);
        push_up(t0 + 2, 1'b0, 64'h0, 1'b1);
        step(); up_idle();
        #1;
        check("mis_err1_resp_rdy", 64'({HRESP_S, HREADYOUT_S}), 64'h2);
        check("mis_htrans1", 64'(HTRANS_M), 64'h0);
        step();
        #1;
        check("mis_htrans2", 64'(HTRANS_M), 64'h0);
        step();

        // Reset asserted in DATA1 of a dword read.
        up_addr(32'h6000, 1'b0, 3'd3);
        push_dn(2'b10, 32'h6000, 1'b0, 3'd2, 1'b0, 32'h0);
        HWDATA_S = 64'hCAFEF00D_CAFEF00D;
        step(); up_idle();
        step();
        check("pre_rst_htrans_seq", 64'(HTRANS_M), 64'h3);
        HRESET = 1'b1;
        #1;
        check("midrst_ctrl", 64'({HTRANS_M, HWRITE_M, HSIZE_M, HREADYOUT_S, HRESP_S}), 64'h02);
        check("midrst_haddr", 64'(HADDR_M), 64'h0);
        check("midrst_hwdata", 64'(HWDATA_M), 64'h0);
        step(); HRESET = 1'b0; HWDATA_S = '0;

        // Word write at 0x700C, then a word read accepted in its completion cycle.
        t0 = cyc;
        up_addr(32'h700C, 1'b1, 3'd2);
        push_dn(2'b10, 32'h700C, 1'b1, 3'd2, 1'b1, 32'hDEADBEEF);
        push_up(t0 + 2, 1'b0, 64'h0, 1'b0);
        step();
        up_addr(32'h8000, 1'b0, 3'd2);
        HWDATA_S = 64'hDEADBEEF_00000000;
        push_dn(2'b10, 32'h8000, 1'b0, 3'd2, 1'b0, 32'h0);
        push_up(t0 + 4, 1'b1, 64'h00000000_12345678, 1'b0);
        step();
        step(); up_idle(); HWDATA_S = '0;
        step(); dn_drive(1'b1, 32'h12345678, 1'b0);
        step(); dn_drive(1'b1, 32'h0, 1'b0);
        repeat (3) step();

        check("up_queue_drained", 64'(up_q.size()), 64'h0);
        check("dn_queue_drained", 64'(dn_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
